fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipelined RV32I core: holds the program counter, reads the instruction ROM, and drives the IF/ID pipeline register consumed by the decode stage. It accepts a stall from the hazard unit and a redirect (taken branch/jump) from EX, and inserts bubbles on redirect. It exposes a fetch counter and a sticky misalignment flag for the processor debug outputs and top-level bench.

## Interface
- `IMEM_DEPTH`, 256, instruction ROM depth in 32-bit words (power of two)
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IMEM_INIT`, "imem.hex", `$readmemh` image for the ROM
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `stall_i`  in  1  hold PC and IF/ID (load-use hazard from hazard unit)
- `redirect_i`  in  1  taken branch/jump resolved in EX
- `redirect_pc_i`  in  32  redirect target
- `pc_o`  out  32  current fetch PC
- `if_id_valid_o`  out  1  IF/ID holds a real instruction
- `if_id_instr_o`  out  32  IF/ID instruction
- `if_id_pc_o`  out  32  PC of IF/ID instruction
- `if_id_pc4_o`  out  32  that PC + 4 (for JAL/JALR link)
- `fetch_count_o`  out  32  number of valid instructions loaded into IF/ID
- `misaligned_o`  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- ROM read is combinational: word index `pc[log2(IMEM_DEPTH)+1:2]`; PC at or above `4*IMEM_DEPTH` returns NOP (32'h0000_0013).
- Priority per rising edge: reset > redirect > stall > advance.
- Reset (`rst_n`=0): `pc_o`=RESET_PC, `if_id_valid_o`=0, `if_id_instr_o`=NOP, `if_id_pc_o`=0, `if_id_pc4_o`=0, `fetch_count_o`=0, `misaligned_o`=0.
- Redirect: PC <= {redirect_pc_i[31:2],2'b00}; IF/ID flushed (valid=0, instr=NOP, pc fields unchanged); count unchanged; `misaligned_o` set if redirect_pc_i[1:0]!=0. Redirect overrides a simultaneous stall.
- Stall (no redirect): PC, IF/ID, count all hold.
- Advance: IF/ID <= {1, rom[pc], pc, pc+4}; PC <= pc+4; count +1.
- PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 -> 0). Count wraps at 2^32.
- Flushing the instruction already in ID on redirect is decode/EX's responsibility; this block only kills the slot being fetched.
- No FSM beyond the PC/valid state; the stage is always in FETCH once reset is released.

## Timing
- Latency: ROM word at PC appears on IF/ID one edge after PC is presented.
- First edge with `rst_n`=1: IF/ID = instr@RESET_PC, valid=1, `pc_o`=RESET_PC+4.
- Redirect sampled at edge N: edge N gives bubble in IF/ID, `pc_o`=target; edge N+1 gives instr@target, valid=1. Penalty from fetch view: 1 bubble.
- Stall held K cycles: IF/ID and `pc_o` constant for K edges, then resume with no lost or duplicated instruction.
- Reset asserted mid-run: all outputs at reset values after that edge regardless of stall/redirect.
- `misaligned_o` cleared only by reset.

## Structure
- Shared header `rv_pipe_defs.vh`: XLEN=32, NOP encoding 32'h0000_0013, default RESET_PC; the IF/ID field layout (valid, instr, pc, pc4) as width/offset constants reused by decode.
- One sub-module: `imem_rom` (parameterised depth and init file, combinational read, out-of-range -> NOP).
- PC register, IF/ID register, counter and sticky flag live in `fetch_stage`.

## Test plan
- Reset release, ROM = {0x00500093, 0x00A00113, 0x002081B3}: edges 1..3 show IF/ID pc 0x0/0x4/0x8 with those words, valid=1, `fetch_count_o`=3.
- Stall asserted 3 cycles after second fetch: IF/ID stays pc=0x4, instr 0x00A00113, count=2 for 3 edges; then pc=0x8 follows.
- Redirect to 0x40 at edge with IF/ID pc=0x8: next edge valid=0, instr=NOP, `pc_o`=0x40; following edge IF/ID pc=0x40, pc4=0x44.
- Redirect and stall same cycle, target 0x22: redirect wins, `pc_o`=0x20, `misaligned_o`=1, stays 1 after later stalls/redirects.
- Fetch past ROM end (IMEM_DEPTH=4, run 6 fetches): pc 0x10, 0x14 return 0x00000013, valid=1.
- Reset asserted mid-stall with pending redirect: after edge all outputs at reset values, `fetch_count_o`=0; next edge fetches RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its consumers:
// data width, NOP encoding, default reset PC and the IF/ID field layout.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IF/ID register layout (LSB first: pc4, pc, instr, valid); decode
    // reuses these offsets when it unpacks the flattened register.
    localparam int unsigned IFID_PC4_OFF   = 0;
    localparam int unsigned IFID_PC4_W     = XLEN;
    localparam int unsigned IFID_PC_OFF    = IFID_PC4_OFF + IFID_PC4_W;
    localparam int unsigned IFID_PC_W      = XLEN;
    localparam int unsigned IFID_INSTR_OFF = IFID_PC_OFF + IFID_PC_W;
    localparam int unsigned IFID_INSTR_W   = 32;
    localparam int unsigned IFID_VALID_OFF = IFID_INSTR_OFF + IFID_INSTR_W;
    localparam int unsigned IFID_VALID_W   = 1;
    localparam int unsigned IFID_W         = IFID_VALID_OFF + IFID_VALID_W;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Word-align a redirect target.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_imem_rom.sv
// Instruction ROM: combinational word read, addresses past the end of the
// array return a NOP. The image is a constant parameter (word i sits at
// bits [32*i +: 32]), so the array synthesises to pure logic or a ROM macro.
module imem_rom
    import fetch_stage_pkg::*;
#(
    parameter int unsigned                DEPTH = 256,
    parameter logic [DEPTH*32-1:0]        IMAGE = {DEPTH{NOP_INSTR}}
) (
    input  logic [31:0] addr,
    output logic [31:0] data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]   idx_s;
    logic            in_range_s;
    logic [AW+4:0]   bit_off_s;
    logic [1:0]      unused_byte_s;

    assign unused_byte_s = addr[1:0];

    // Decode the word index and select the ROM word or a NOP when out of range.
    always_comb begin
        idx_s      = addr[AW+1:2];
        bit_off_s  = {idx_s, 5'b00000};
        in_range_s = ((addr >> (AW + 2)) == 32'd0);
        if (in_range_s) begin
            data = IMAGE[bit_off_s +: 32];
        end else begin
            data = NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, ROM lookup and the IF/ID
// pipeline register. Redirect from EX beats a hazard stall; a redirect only
// kills the slot being fetched (the instruction already in ID is the
// downstream stages' concern). Also keeps a fetch counter and a sticky
// flag for misaligned redirect targets.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned              IMEM_DEPTH = 256,
    parameter logic [31:0]              RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [IMEM_DEPTH*32-1:0] IMEM_IMAGE = {IMEM_DEPTH{NOP_INSTR}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] fetch_count_o,
    output logic        misaligned_o
);

    logic [31:0] pc_r;
    if_id_t      if_id_r;
    logic [31:0] count_r;
    logic        misaligned_r;

    logic [31:0] rom_word_s;
    logic        target_misaligned_s;

    imem_rom #(
        .DEPTH (IMEM_DEPTH),
        .IMAGE (IMEM_IMAGE)
    ) u_rom (
        .addr (pc_r),
        .data (rom_word_s)
    );

    assign target_misaligned_s = (redirect_pc_i[1:0] != 2'b00);

    // Program counter: reset vector, redirect target, hold on stall, else +4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_i) begin
            pc_r <= pc_align(redirect_pc_i);
        end else if (stall_i) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc_next_seq(pc_r);
        end
    end

    // IF/ID register: bubble on redirect (pc fields kept), hold on stall, load on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_r.valid <= 1'b0;
            if_id_r.instr <= NOP_INSTR;
            if_id_r.pc    <= 32'h0000_0000;
            if_id_r.pc4   <= 32'h0000_0000;
        end else if (redirect_i) begin
            if_id_r.valid <= 1'b0;
            if_id_r.instr <= NOP_INSTR;
            if_id_r.pc    <= if_id_r.pc;
            if_id_r.pc4   <= if_id_r.pc4;
        end else if (stall_i) begin
            if_id_r <= if_id_r;
        end else begin
            if_id_r.valid <= 1'b1;
            if_id_r.instr <= rom_word_s;
            if_id_r.pc    <= pc_r;
            if_id_r.pc4   <= pc_next_seq(pc_r);
        end
    end

    // Fetch counter: counts instructions actually loaded into IF/ID, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (redirect_i || stall_i) begin
            count_r <= count_r;
        end else begin
            count_r <= count_r + 32'd1;
        end
    end

    // Sticky misalignment flag: set by any misaligned redirect, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_r <= 1'b0;
        end else if (redirect_i) begin
            misaligned_r <= misaligned_r | target_misaligned_s;
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign pc_o          = pc_r;
    assign if_id_valid_o = if_id_r.valid;
    assign if_id_instr_o = if_id_r.instr;
    assign if_id_pc_o    = if_id_r.pc;
    assign if_id_pc4_o   = if_id_r.pc4;
    assign fetch_count_o = count_r;
    assign misaligned_o  = misaligned_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, all checked against a cycle-level model
// of the fetch rules kept in plain variables.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [DEPTH*32-1:0] IMG = {32'h0030_8233, 32'h0020_81B3,
                                           32'h00A0_0113, 32'h0050_0093};

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] fetch_count_o;
    logic        misaligned_o;

    int vec_count  = 0;
    int miscompare = 0;

    // Reference state
    logic [31:0] rom_words [DEPTH];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifpc4;
    logic [31:0] m_count;
    logic        m_mis;

    fetch_stage #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (RST_PC),
        .IMEM_IMAGE (IMG)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .if_id_valid_o (if_id_valid_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .fetch_count_o (fetch_count_o),
        .misaligned_o  (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        logic [31:0] w;
        if (a < 32'(DEPTH * 4)) begin
            w = rom_words[a[3:2]];
        end else begin
            w = NOP;
        end
        return w;
    endfunction

    task automatic model_edge(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        if (rst) begin
            m_pc = RST_PC; m_valid = 1'b0; m_instr = NOP;
            m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_count = 32'd0; m_mis = 1'b0;
        end else if (rd) begin
            m_pc = tgt - (tgt % 32'd4);
            m_valid = 1'b0;
            m_instr = NOP;
            if ((tgt % 32'd4) != 32'd0) m_mis = 1'b1;
        end else if (!st) begin
            m_valid = 1'b1;
            m_instr = rom_at(m_pc);
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic compare_all();
        check_val("pc",       pc_o,                 m_pc);
        check_val("valid",    {31'd0, if_id_valid_o}, {31'd0, m_valid});
        check_val("instr",    if_id_instr_o,        m_instr);
        check_val("if_pc",    if_id_pc_o,           m_ifpc);
        check_val("if_pc4",   if_id_pc4_o,          m_ifpc4);
        check_val("count",    fetch_count_o,        m_count);
        check_val("misalign", {31'd0, misaligned_o},  {31'd0, m_mis});
    endtask

    // One clock edge: drive at negedge, update model at posedge, sample 1 ns later.
    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        rst_n         = ~rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        @(posedge clk);
        model_edge(rst, st, rd, tgt);
        #1;
        compare_all();
    endtask

    initial begin
        rom_words[0] = 32'h0050_0093;
        rom_words[1] = 32'h00A0_0113;
        rom_words[2] = 32'h0020_81B3;
        rom_words[3] = 32'h0030_8233;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Two fetches, 3-cycle stall, then resume at 0x8
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            check_val("stall_hold_pc",    if_id_pc_o,    32'h0000_0004);
            check_val("stall_hold_instr", if_id_instr_o, 32'h00A0_0113);
            check_val("stall_hold_count", fetch_count_o, 32'd2);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("third_fetch", if_id_instr_o, 32'h0020_81B3);
        check_val("third_count", fetch_count_o, 32'd3);

        // Redirect to 0x40 with IF/ID pc = 0x8
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check_val("redir_bubble", {31'd0, if_id_valid_o}, 32'd0);
        check_val("redir_pc", pc_o, 32'h0000_0040);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("redir_ifpc4", if_id_pc4_o, 32'h0000_0044);

        // Redirect + stall together, misaligned target
        step(1'b0, 1'b1, 1'b1, 32'h0000_0022);
        check_val("mis_pc", pc_o, 32'h0000_0020);
        check_val("mis_flag", {31'd0, misaligned_o}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        check_val("mis_sticky", {31'd0, misaligned_o}, 32'd1);

        // Six fetches from 0: last two are past the ROM end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("past_end_instr", if_id_instr_o, NOP);
        check_val("past_end_pc", if_id_pc_o, 32'h0000_0014);

        // PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("wrap_pc", pc_o, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset during stall with pending redirect, then first fetch
        step(1'b1, 1'b1, 1'b1, 32'h0000_0013);
        check_val("rst_count", fetch_count_o, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("rst_refetch", if_id_instr_o, 32'h0050_0093);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            d = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 9) == 0) t = $urandom;
            else if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else t = 32'($urandom_range(0, 31));
            step(r, s, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
